bcd_accumulator: RTL and testbench
==================================

Name: bcd_accumulator

Overview:
- Two-digit packed-BCD accumulator that sits directly upstream of the team's BCD-to-seven-segment display stage.
- Accepts a two-digit BCD operand through a valid/ready handshake and adds it digit-serially (ones, then tens) into a registered running total.
- Exposes the total digits plus a carry flag; the carry drives the hundreds digit of the display, which shows 0 or 1.

Parameters:
- SATURATE, 0: 0 = total wraps modulo 100 on overflow; 1 = total clamps to 99 on overflow.

Ports:
- clk  input  1  system clock; every register updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- op_valid  input  1  an operation is presented this cycle.
- op_ready  output  1  block can accept an operation this cycle.
- op_clr  input  1  qualified by op_valid: 1 = clear the total, 0 = add op_bcd.
- op_bcd  input  8  operand; [7:4] is tens digit, [3:0] is ones digit.
- acc_bcd  output  8  running total; [7:4] is tens, [3:0] is ones.
- carry  output  1  carry out of the tens digit from the last completed add.
- err  output  1  the last accepted add had a non-BCD digit.
- done  output  1  one-cycle pulse when an operation completes.

Behaviour:
- Reset (rst=1 at a rising edge): state=IDLE, acc_bcd=8'h00, carry=0, err=0, done=0, op_ready=1.
- rst has priority over everything, including an operation in flight; that operation is abandoned with no done pulse.
- States: IDLE, ONES, TENS. op_ready=1 only in IDLE. The operation is accepted on a cycle where op_valid=1 and op_ready=1.
- Accepted clear (op_clr=1):
  - Next edge: acc_bcd=00, carry=0, err=0, done=1.
  - State stays IDLE; op_bcd is ignored.
- Accepted add, invalid operand (op_clr=0, either digit of op_bcd > 9):
  - Next edge: err=1, done=1; acc_bcd and carry unchanged.
  - State stays IDLE.
- Accepted add, valid operand:
  - Operand is latched internally; IDLE -> ONES.
  - ONES: s0 = acc[3:0] + opnd[3:0]; if s0 > 9, ones = s0 - 10 and c0 = 1, else ones = s0 and c0 = 0. Result goes into an internal register. ONES -> TENS.
  - TENS: s1 = acc[7:4] + opnd[7:4] + c0, corrected the same way to give tens and c1.
  - At the end of TENS, acc_bcd = {tens, ones}, carry = c1, err = 0, done = 1, and TENS -> IDLE.
  - If SATURATE=1 and c1=1: acc_bcd = 8'h99, carry = 1.
- Widths: digit sums use 5-bit intermediates (maximum 9+9+1=19). Correction is subtract-10 on the 5-bit value, keeping bits [3:0].
- Timing: for an add accepted at edge N, acc_bcd/carry/done update at edge N+2, and op_ready is high again in the cycle after N+2. Back-to-back adds therefore sustain one per 3 cycles.
- acc_bcd holds its old value throughout ONES and TENS and changes in one step.
- done is high for exactly one cycle per completed operation and is 0 otherwise.
- An op_valid asserted while op_ready=0 is not accepted. The source must hold it until acceptance; no input is sampled outside IDLE except rst.
- Every output is registered.

Test Plan:
- Reset, then clear, then add 8'h25, then add 8'h38 -> acc_bcd=63, carry=0, done pulses 2 cycles after each acceptance, and acc is stable at 25 during the second add.
- acc=63, add 8'h47 -> ones 3+7=10 gives 0 with c0=1, tens 6+4+1=11 gives 1 with c1=1 -> acc_bcd=10, carry=1. With SATURATE=1 the same stimulus gives acc_bcd=99, carry=1.
- acc=10, add 8'h3C -> err=1, done at the next edge, acc_bcd=10, carry unchanged. A following valid add of 8'h01 gives acc_bcd=11, err=0.
- op_valid held high with op_bcd=8'h99 from acc=00 -> accepted every 3rd cycle; totals go 99, 98 with carry=1, then 97 with carry=1. op_ready is low in the cycles where the FSM is in ONES or TENS.
- Start add 8'h55 from acc=42, assert rst during TENS -> acc_bcd=00, carry=0, no done pulse, op_ready=1 at the next cycle.
- Clear accepted with op_bcd=8'hFF and err=1 -> acc_bcd=00, carry=0, err=0, done=1 one cycle later.

Source files
------------

// File: rtl/bcd_accumulator.sv
// Two-digit packed-BCD accumulator feeding the BCD-to-seven-segment stage.
// An operand is taken through a valid/ready handshake and added one digit
// per cycle (ones, then tens) into a registered running total.
//
// State | Meaning
// ------+-------------------------------------------------------------
// IDLE  | ready for an operation; a clear or an invalid add finishes here
// ONES  | add the ones digits and hold the result and digit carry
// TENS  | add the tens digits plus the ones carry, then update the total
//
// Ports:
//   clk       system clock, rising edge
//   rst       synchronous reset, active-high
//   op_valid  operation presented
//   op_ready  operation can be accepted (IDLE only)
//   op_clr    1 = clear the total, 0 = add op_bcd
//   op_bcd    operand, [7:4] tens, [3:0] ones
//   acc_bcd   running total, [7:4] tens, [3:0] ones
//   carry     carry out of the tens digit of the last completed add
//   err       last accepted add had a non-BCD digit
//   done      one-cycle pulse when an operation completes
module bcd_accumulator #(
   parameter bit SATURATE = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       op_valid,
   output logic       op_ready,
   input  logic       op_clr,
   input  logic [7:0] op_bcd,
   output logic [7:0] acc_bcd,
   output logic       carry,
   output logic       err,
   output logic       done
);

   typedef enum logic [1:0] {IDLE, ONES, TENS} state_t;

   state_t     state, state_nxt;
   logic [7:0] opnd, opnd_nxt;
   logic [3:0] ones_r, ones_nxt;
   logic       c0_r, c0_nxt;
   logic [7:0] acc_nxt;
   logic       carry_nxt, err_nxt, done_nxt, ready_nxt;

   logic       accept, op_is_bcd;
   logic [4:0] s0, s0_adj, s1, s1_adj;
   logic [3:0] ones_d, tens_d;
   logic       c0_d, c1_d;

   // op_ready is a registered copy of (state == IDLE)
   assign accept    = op_valid & op_ready;
   assign op_is_bcd = (op_bcd[7:4] <= 4'd9) && (op_bcd[3:0] <= 4'd9);

   // Digit adders: the total is stable during ONES/TENS, so both read acc_bcd.
   always_comb begin
      s0     = {1'b0, acc_bcd[3:0]} + {1'b0, opnd[3:0]};
      s0_adj = s0 - 5'd10;
      c0_d   = (s0 > 5'd9);
      ones_d = c0_d ? s0_adj[3:0] : s0[3:0];
      s1     = {1'b0, acc_bcd[7:4]} + {1'b0, opnd[7:4]} + {4'd0, c0_r};
      s1_adj = s1 - 5'd10;
      c1_d   = (s1 > 5'd9);
      tens_d = c1_d ? s1_adj[3:0] : s1[3:0];
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (accept && !op_clr && op_is_bcd) state_nxt = ONES;
         ONES: state_nxt = TENS;
         TENS: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      opnd_nxt  = opnd;
      ones_nxt  = ones_r;
      c0_nxt    = c0_r;
      acc_nxt   = acc_bcd;
      carry_nxt = carry;
      err_nxt   = err;
      done_nxt  = 1'b0;
      ready_nxt = (state_nxt == IDLE);
      case (state)
         IDLE: begin
            if (accept) begin
               if (op_clr) begin
                  acc_nxt   = 8'h00;
                  carry_nxt = 1'b0;
                  err_nxt   = 1'b0;
                  done_nxt  = 1'b1;
               end else if (!op_is_bcd) begin
                  err_nxt  = 1'b1;
                  done_nxt = 1'b1;
               end else begin
                  opnd_nxt = op_bcd;
               end
            end
         end
         ONES: begin
            ones_nxt = ones_d;
            c0_nxt   = c0_d;
         end
         TENS: begin
            acc_nxt   = {tens_d, ones_r};
            carry_nxt = c1_d;
            err_nxt   = 1'b0;
            done_nxt  = 1'b1;
            if (SATURATE && c1_d) acc_nxt = 8'h99;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         opnd     <= 8'h00;
         ones_r   <= 4'd0;
         c0_r     <= 1'b0;
         acc_bcd  <= 8'h00;
         carry    <= 1'b0;
         err      <= 1'b0;
         done     <= 1'b0;
         op_ready <= 1'b1;
      end else begin
         opnd     <= opnd_nxt;
         ones_r   <= ones_nxt;
         c0_r     <= c0_nxt;
         acc_bcd  <= acc_nxt;
         carry    <= carry_nxt;
         err      <= err_nxt;
         done     <= done_nxt;
         op_ready <= ready_nxt;
      end
   end

endmodule

// File: tb/tb_bcd_accumulator.sv
// Bench for bcd_accumulator: a wrapping and a saturating instance share the
// same stimulus; expected completions are queued per instance and checked by
// monitors whenever done pulses.
module tb_bcd_accumulator;

   logic       clk = 1'b0;
   logic       rst, op_valid, op_clr;
   logic [7:0] op_bcd;
   logic       r0, c0, e0, d0, r1, c1, e1, d1;
   logic [7:0] a0, a1;

   typedef struct {
      logic [7:0] acc;
      logic       cy;
      logic       er;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   int   checks = 0;
   int   errors = 0;

   logic [7:0] b2b_acc0 [3];
   logic [7:0] b2b_acc1 [3];
   logic       b2b_cy   [3];

   always #5 clk = ~clk;

   bcd_accumulator #(.SATURATE(1'b0)) dut0 (
      .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(r0), .op_clr(op_clr),
      .op_bcd(op_bcd), .acc_bcd(a0), .carry(c0), .err(e0), .done(d0));

   bcd_accumulator #(.SATURATE(1'b1)) dut1 (
      .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(r1), .op_clr(op_clr),
      .op_bcd(op_bcd), .acc_bcd(a1), .carry(c1), .err(e1), .done(d1));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, expv, $time);
      end
   endtask

   always @(negedge clk) begin : mon0
      exp_t e;
      if (d0 === 1'b1) begin
         if (q0.size() == 0) begin
            checks++; errors++;
            $display("FAIL sat0_unexpected_done: got done=1, expected no completion at %0t", $time);
         end else begin
            e = q0.pop_front();
            check("sat0_acc", a0, e.acc);
            check("sat0_carry", c0, e.cy);
            check("sat0_err", e0, e.er);
         end
      end
   end

   always @(negedge clk) begin : mon1
      exp_t e;
      if (d1 === 1'b1) begin
         if (q1.size() == 0) begin
            checks++; errors++;
            $display("FAIL sat1_unexpected_done: got done=1, expected no completion at %0t", $time);
         end else begin
            e = q1.pop_front();
            check("sat1_acc", a1, e.acc);
            check("sat1_carry", c1, e.cy);
            check("sat1_err", e1, e.er);
         end
      end
   end

   task automatic push_exp(input logic [7:0] acc0, input logic cy0,
                           input logic [7:0] acc1, input logic cy1, input logic er);
      exp_t t;
      t.acc = acc0; t.cy = cy0; t.er = er; q0.push_back(t);
      t.acc = acc1; t.cy = cy1; t.er = er; q1.push_back(t);
   endtask

   // Issue one operation and check handshake timing; results go via the queues.
   task automatic do_op(input logic clr, input logic [7:0] bcd,
                        input logic [7:0] acc0, input logic cy0,
                        input logic [7:0] acc1, input logic cy1, input logic er);
      logic [7:0] pre0, pre1;
      logic       slow;
      int         n;
      slow = !clr && (bcd[7:4] <= 4'd9) && (bcd[3:0] <= 4'd9);
      @(negedge clk);
      n = 0;
      while (!(r0 && r1) && n < 10) begin
         @(negedge clk);
         n++;
      end
      if (n >= 10) begin
         checks++; errors++;
         $display("FAIL ready_timeout: got op_ready=%0b/%0b, expected 1", r0, r1);
      end
      pre0 = a0; pre1 = a1;
      op_valid = 1'b1; op_clr = clr; op_bcd = bcd;
      push_exp(acc0, cy0, acc1, cy1, er);
      @(posedge clk); #1;
      op_valid = 1'b0;
      if (!slow) begin
         check("fast_done", {d1, d0}, 2'b11);
         check("fast_ready", {r1, r0}, 2'b11);
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (i == 1) @(posedge clk); #1;
            check("busy_ready", {r1, r0}, 2'b00);
            check("busy_done", {d1, d0}, 2'b00);
            check("acc_hold0", a0, pre0);
            check("acc_hold1", a1, pre1);
         end
         @(posedge clk); #1;
         check("add_done_lat2", {d1, d0}, 2'b11);
         check("add_ready_back", {r1, r0}, 2'b11);
         @(posedge clk); #1;
         check("done_one_cycle", {d1, d0}, 2'b00);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, expected completion within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      b2b_acc0 = '{8'h99, 8'h98, 8'h97};
      b2b_acc1 = '{8'h99, 8'h99, 8'h99};
      b2b_cy   = '{1'b0, 1'b1, 1'b1};
      rst = 1'b1; op_valid = 1'b0; op_clr = 1'b0; op_bcd = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      check("rst_acc", {a1, a0}, 16'h0000);
      check("rst_carry", {c1, c0}, 2'b00);
      check("rst_err", {e1, e0}, 2'b00);
      check("rst_done", {d1, d0}, 2'b00);
      check("rst_ready", {r1, r0}, 2'b11);
      rst = 1'b0;

      //     clr   bcd    acc0   cy0   acc1   cy1   err
      do_op(1'b1, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
      do_op(1'b0, 8'h25, 8'h25, 1'b0, 8'h25, 1'b0, 1'b0);
      do_op(1'b0, 8'h38, 8'h63, 1'b0, 8'h63, 1'b0, 1'b0);
      do_op(1'b0, 8'h47, 8'h10, 1'b1, 8'h99, 1'b1, 1'b0);
      do_op(1'b0, 8'h3C, 8'h10, 1'b1, 8'h99, 1'b1, 1'b1);
      do_op(1'b0, 8'h01, 8'h11, 1'b0, 8'h99, 1'b1, 1'b0);
      do_op(1'b0, 8'h3C, 8'h11, 1'b0, 8'h99, 1'b1, 1'b1);
      do_op(1'b1, 8'hFF, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);

      // op_valid held high: one acceptance every third cycle
      @(negedge clk);
      op_valid = 1'b1; op_clr = 1'b0; op_bcd = 8'h99;
      for (int k = 0; k < 3; k++) begin
         push_exp(b2b_acc0[k], b2b_cy[k], b2b_acc1[k], b2b_cy[k], 1'b0);
         @(posedge clk); #1;
         check("b2b_ready_ones", {r1, r0}, 2'b00);
         @(posedge clk); #1;
         check("b2b_ready_tens", {r1, r0}, 2'b00);
         check("b2b_done_early", {d1, d0}, 2'b00);
         @(posedge clk); #1;
         check("b2b_done", {d1, d0}, 2'b11);
         check("b2b_ready_back", {r1, r0}, 2'b11);
         if (k == 2) op_valid = 1'b0;
      end

      // reset during TENS abandons the add
      do_op(1'b1, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
      do_op(1'b0, 8'h42, 8'h42, 1'b0, 8'h42, 1'b0, 1'b0);
      @(negedge clk);
      op_valid = 1'b1; op_clr = 1'b0; op_bcd = 8'h55;
      @(posedge clk); #1;
      op_valid = 1'b0;
      @(posedge clk); #1;
      check("abort_in_tens_ready", {r1, r0}, 2'b00);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("abort_no_done", {d1, d0}, 2'b00);
      check("abort_acc", {a1, a0}, 16'h0000);
      check("abort_carry", {c1, c0}, 2'b00);
      check("abort_ready", {r1, r0}, 2'b11);
      repeat (3) @(posedge clk);
      #1;
      check("abort_still_no_done", {d1, d0}, 2'b00);

      check("queue0_drained", q0.size(), 0);
      check("queue1_drained", q1.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
